// File: rtl/mdu_issue.sv
// mdu_issue: issue/retire stage in front of mdu_top.
// Ports: i_clk/i_rst (async active-high); execute side i_valid/o_ready,
// i_funct3, i_rd, i_rs1, i_rs2; unit side o_mdu_valid, o_mdu_op, o_mdu_rs1,
// o_mdu_rs2, i_mdu_ready, i_mdu_rd; writeback side o_wb_valid, o_wb_rd,
// o_wb_data, i_wb_ready.
// Define MDU_ISSUE_FASTDIV_EN to resolve divide-by-zero and signed overflow
// locally without occupying the unit.
module mdu_issue #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_funct3,
  input  logic [4:0]       i_rd,
  input  logic [WIDTH-1:0] i_rs1,
  input  logic [WIDTH-1:0] i_rs2,
  output logic             o_mdu_valid,
  output logic [2:0]       o_mdu_op,
  output logic [WIDTH-1:0] o_mdu_rs1,
  output logic [WIDTH-1:0] o_mdu_rs2,
  input  logic             i_mdu_ready,
  input  logic [WIDTH-1:0] i_mdu_rd,
  output logic             o_wb_valid,
  output logic [4:0]       o_wb_rd,
  output logic [WIDTH-1:0] o_wb_data,
  input  logic             i_wb_ready
);
  // State bits double as the registered valid outputs: bit0 = BUSY, bit1 = RESP.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;
  logic [1:0]       state;
  logic             fast;
  logic [WIDTH-1:0] fast_data;
`ifdef MDU_ISSUE_FASTDIV_EN
  logic div_zero;
  logic ovf;
  assign div_zero  = i_rs2 == '0;
  assign ovf       = !i_funct3[0] && i_rs1 == {1'b1, {(WIDTH-1){1'b0}}} && &i_rs2;
  assign fast      = i_funct3[2] && (div_zero || ovf);
  // funct3[1] selects remainder; on overflow the quotient equals rs1.
  assign fast_data = div_zero ? (i_funct3[1] ? i_rs1 : '1) : (i_funct3[1] ? '0 : i_rs1);
`else
  assign fast      = 1'b0;
  assign fast_data = '0;
`endif
  assign o_ready     = state == S_IDLE;
  assign o_mdu_valid = state[0];
  assign o_wb_valid  = state[1];
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      o_mdu_op  <= '0;
      o_mdu_rs1 <= '0;
      o_mdu_rs2 <= '0;
      o_wb_rd   <= '0;
      o_wb_data <= '0;
    end else if (state == S_IDLE && i_valid) begin
      o_mdu_op  <= i_funct3;
      o_mdu_rs1 <= i_rs1;
      o_mdu_rs2 <= i_rs2;
      o_wb_rd   <= i_rd;
      state     <= fast ? S_RESP : S_BUSY;
      if (fast) o_wb_data <= fast_data;
    end else if (state == S_BUSY && i_mdu_ready) begin
      o_wb_data <= i_mdu_rd;
      state     <= S_RESP;
    end else if (state == S_RESP && i_wb_ready) begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_mdu_issue.sv
// tb_mdu_issue: table-driven check of mdu_issue against a behavioural mdu_top model
module tb_mdu_issue;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_funct3 = '0;
  logic [4:0]  i_rd = '0;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic        o_mdu_valid;
  logic [2:0]  o_mdu_op;
  logic [31:0] o_mdu_rs1;
  logic [31:0] o_mdu_rs2;
  logic        i_mdu_ready = 1'b0;
  logic [31:0] i_mdu_rd = '0;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        i_wb_ready = 1'b0;
  int n_chk = 0;
  int n_err = 0;
`ifdef MDU_ISSUE_FASTDIV_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          lat;
    int          hold;
    logic        fz;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[14];
  vec_t mulhu_v;
  mdu_issue #(.WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_funct3(i_funct3), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .o_mdu_valid(o_mdu_valid), .o_mdu_op(o_mdu_op), .o_mdu_rs1(o_mdu_rs1),
    .o_mdu_rs2(o_mdu_rs2), .i_mdu_ready(i_mdu_ready), .i_mdu_rd(i_mdu_rd),
    .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .i_wb_ready(i_wb_ready)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [31:0] unit_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int x, y;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    x = $signed(a);
    y = $signed(b);
    p = (f == 3'd1) ? 64'(sa * sb) : (f == 3'd2) ? 64'(sa * ub) : 64'(ua * ub);
    if (!f[2]) return (f == 3'd0) ? p[31:0] : p[63:32];
    if (b == 0) return f[1] ? a : 32'hFFFFFFFF;
    if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'd0 : a;
    case (f)
      3'd4:    return 32'(x / y);
      3'd5:    return a / b;
      3'd6:    return 32'(x % y);
      default: return a % b;
    endcase
  endfunction
  task automatic run(input string tag, input vec_t v);
    int c, busy_n, held, wbc;
    logic ops_ok, bp_ok, done, fast;
    logic [31:0] data;
    logic [4:0] rd;
    fast = FAST && v.fz;
    @(negedge i_clk);
    chk({tag, ".ready_in"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_funct3 = v.f; i_rs1 = v.a; i_rs2 = v.b; i_rd = v.rd;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_funct3 = ~v.f; i_rs1 = ~v.a; i_rs2 = ~v.b; i_rd = ~v.rd;
    c = 1; busy_n = 0; held = 0; wbc = -1; ops_ok = 1; bp_ok = 1; done = 0;
    data = '0; rd = '0;
    while (!done && c < 200) begin
      i_mdu_ready = 1'b0; i_mdu_rd = 32'hDEADBEEF; i_wb_ready = 1'b0; i_valid = 1'b0;
      if (o_mdu_valid) begin
        busy_n++;
        i_wb_ready = 1'b1;
        if (o_mdu_op !== v.f || o_mdu_rs1 !== v.a || o_mdu_rs2 !== v.b) ops_ok = 0;
        if (busy_n == v.lat) begin
          i_mdu_ready = 1'b1;
          i_mdu_rd = unit_model(o_mdu_op, o_mdu_rs1, o_mdu_rs2);
        end
      end
      if (o_wb_valid) begin
        if (wbc < 0) begin wbc = c; data = o_wb_data; rd = o_wb_rd; end
        if (o_wb_data !== data || o_wb_rd !== rd || o_ready !== 1'b0 || o_mdu_valid !== 1'b0) bp_ok = 0;
        if (held < v.hold) begin
          held++;
          i_valid = 1'b1; i_funct3 = 3'd0; i_rs1 = 32'd99; i_rs2 = 32'd99;
          i_mdu_ready = 1'b1; i_mdu_rd = 32'h0BADF00D;
        end else begin
          done = 1;
          i_wb_ready = 1'b1;
        end
      end
      @(posedge i_clk); #1;
      c++;
    end
    i_wb_ready = 1'b0; i_mdu_ready = 1'b0; i_valid = 1'b0;
    chk({tag, ".data"}, data, v.exp);
    chk({tag, ".rd"}, 32'(rd), 32'(v.rd));
    chk({tag, ".wb_cycle"}, 32'(wbc), fast ? 32'd1 : 32'(v.lat + 1));
    chk({tag, ".busy_cycles"}, 32'(busy_n), fast ? 32'd0 : 32'(v.lat));
    chk({tag, ".ops_stable"}, 32'(ops_ok), 32'd1);
    chk({tag, ".resp_stable"}, 32'(bp_ok), 32'd1);
    chk({tag, ".ready_after"}, 32'(o_ready), 32'd1);
    chk({tag, ".idle_valids"}, {30'd0, o_mdu_valid, o_wb_valid}, 32'd0);
  endtask
  initial begin
    logic stray;
    tv[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 5'd5,  3, 0,  1'b0, 32'hFFFFFFEB};
    tv[1]  = '{3'd5, 32'd100,        32'd7,        5'd6,  5, 0,  1'b0, 32'd14};
    tv[2]  = '{3'd7, 32'd100,        32'd7,        5'd7,  5, 0,  1'b0, 32'd2};
    tv[3]  = '{3'd0, 32'd6,          32'd7,        5'd3,  2, 10, 1'b0, 32'd42};
    tv[4]  = '{3'd1, 32'h80000000,   32'h80000000, 5'd9,  1, 0,  1'b0, 32'h40000000};
    tv[5]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd10, 4, 0,  1'b0, 32'hFFFFFFFF};
    tv[6]  = '{3'd4, 32'hFFFFFFEC,   32'd3,        5'd11, 6, 0,  1'b0, 32'hFFFFFFFA};
    tv[7]  = '{3'd6, 32'hFFFFFFEC,   32'd3,        5'd12, 2, 0,  1'b0, 32'hFFFFFFFE};
    tv[8]  = '{3'd0, 32'd3,          32'd4,        5'd0,  1, 0,  1'b0, 32'd12};
    tv[9]  = '{3'd4, 32'd5,          32'd0,        5'd13, 3, 0,  1'b1, 32'hFFFFFFFF};
    tv[10] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 5'd14, 3, 0,  1'b1, 32'd0};
    tv[11] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 5'd15, 2, 0,  1'b1, 32'h80000000};
    tv[12] = '{3'd7, 32'd9,          32'd0,        5'd16, 4, 0,  1'b1, 32'd9};
    tv[13] = '{3'd3, 32'd5,          32'd0,        5'd17, 2, 0,  1'b0, 32'd0};
    mulhu_v = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 3, 0, 1'b0, 32'hFFFFFFFE};
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset.valids", {30'd0, o_mdu_valid, o_wb_valid}, 32'd0);
    chk("reset.wb_data", o_wb_data, 32'd0);
    chk("reset.ready", 32'(o_ready), 32'd1);
    @(negedge i_clk); i_rst = 1'b0;
    for (int i = 0; i < 14; i++) run($sformatf("vec%0d", i), tv[i]);
    // Reset while BUSY on a DIV: everything clears at once and nothing retires.
    @(negedge i_clk);
    i_valid = 1'b1; i_funct3 = 3'd4; i_rs1 = 32'd1000; i_rs2 = 32'd3; i_rd = 5'd4;
    @(posedge i_clk); #1 i_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("rst_mid.busy", 32'(o_mdu_valid), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("rst_mid.mdu_valid", 32'(o_mdu_valid), 32'd0);
    chk("rst_mid.op", 32'(o_mdu_op), 32'd0);
    chk("rst_mid.rs1", o_mdu_rs1, 32'd0);
    chk("rst_mid.rs2", o_mdu_rs2, 32'd0);
    chk("rst_mid.wb_rd", 32'(o_wb_rd), 32'd0);
    chk("rst_mid.wb_data", o_wb_data, 32'd0);
    chk("rst_mid.wb_valid", 32'(o_wb_valid), 32'd0);
    @(negedge i_clk); i_rst = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_mdu_ready = 1'b1; i_mdu_rd = 32'd333;
      @(posedge i_clk); #1;
      if (o_wb_valid || o_mdu_valid || !o_ready) stray = 1'b1;
    end
    i_mdu_ready = 1'b0;
    chk("rst_mid.no_retire", 32'(stray), 32'd0);
    chk("rst_mid.wb_data_kept", o_wb_data, 32'd0);
    run("mulhu_after_rst", mulhu_v);
    // Result strobe while IDLE must be ignored.
    @(negedge i_clk);
    i_mdu_ready = 1'b1; i_mdu_rd = 32'h12345678; i_wb_ready = 1'b1;
    @(posedge i_clk); #1;
    i_mdu_ready = 1'b0; i_wb_ready = 1'b0;
    chk("idle_pulse.ready", 32'(o_ready), 32'd1);
    chk("idle_pulse.valids", {30'd0, o_mdu_valid, o_wb_valid}, 32'd0);
    chk("idle_pulse.wb_data", o_wb_data, 32'hFFFFFFFE);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mdu_issue.md
# mdu_issue

Issue/retire stage directly upstream of the multiplication & division unit `mdu_top`. It accepts one decoded M-extension operation at a time from the execute stage and drives the unit's level-sensitive `valid`/`ready` protocol with operands held stable. It registers the unit's result and presents it to writeback on a valid/ready handshake. Optionally it resolves RISC-V divide-by-zero and signed-overflow cases locally without occupying the unit.

## Interface
- `WIDTH`, 32, operand/result width; must match the `mdu_top` instance.
- `i_clk`  in  1  clock; all state updates on its rising edge.
- `i_rst`  in  1  asynchronous active-high reset.
- `i_valid`  in  1  execute stage presents an operation.
- `o_ready`  out  1  block can accept an operation this cycle.
- `i_funct3`  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `i_rd`  in  5  destination register index.
- `i_rs1`, `i_rs2`  in  WIDTH  source operands.
- `o_mdu_valid`  out  1  request to `mdu_top` (`i_mdu_valid`).
- `o_mdu_op`  out  3  operation code to `mdu_top`; equal to the captured funct3.
- `o_mdu_rs1`, `o_mdu_rs2`  out  WIDTH  operands to `mdu_top`.
- `i_mdu_ready`  in  1  result strobe from `mdu_top`.
- `i_mdu_rd`  in  WIDTH  result from `mdu_top`; valid only while `i_mdu_ready`=1.
- `o_wb_valid`  out  1  result available for writeback.
- `o_wb_rd`  out  5  destination index of the result.
- `o_wb_data`  out  WIDTH  result value.
- `i_wb_ready`  in  1  writeback accepts the result.

## Operation
- FSM with three states. IDLE: `o_ready`=1. BUSY: `o_mdu_valid`=1. RESP: `o_wb_valid`=1.
- IDLE, `i_valid`=1: capture funct3, rd, rs1 and rs2 into registers.
  - If the fast path does not apply, go to BUSY.
  - If the fast path applies (see Configuration), load `o_wb_data` and go to RESP.
- BUSY: `o_mdu_op`, `o_mdu_rs1` and `o_mdu_rs2` stay constant at the captured values.
  - On the first cycle with `i_mdu_ready`=1, register `i_mdu_rd` into `o_wb_data` and go to RESP.
- RESP: hold `o_wb_*` stable until `i_wb_ready`=1, then return to IDLE.
- `o_mdu_valid` is low in RESP and in IDLE. This guarantees at least one low cycle between consecutive unit requests, which clears the unit's registered enable and divider done flags.
- rd = 0: the operation still executes and retires through RESP with `o_wb_rd`=0. Writeback discards it.
- `o_ready` is a decode of the IDLE state only and has no combinational path from any input.
- `i_mdu_ready` outside BUSY is ignored. `i_wb_ready` outside RESP is ignored.
- Reset, including mid-operation: FSM goes to IDLE. `o_mdu_valid`, `o_wb_valid`, `o_mdu_op`, `o_mdu_rs1`, `o_mdu_rs2`, `o_wb_rd` and `o_wb_data` all go to 0, and `o_ready` goes to 1 once reset releases. Any in-flight result is discarded. `mdu_top` shares `i_rst` and aborts its divider on the same reset.

## Timing
- Accept edge is cycle 0, when `i_valid`=1 and `o_ready`=1.
- Unit path:
  - `o_mdu_valid`=1 from cycle 1.
  - If `i_mdu_ready` is first seen in cycle k, `o_wb_valid`=1 from cycle k+1.
  - `o_mdu_valid`=0 from cycle k+1.
- Fast path: `o_wb_valid`=1 in cycle 1.
- Throughput is one operation per (unit latency + 2) cycles at best when `i_wb_ready` is held at 1.
- Back-pressure: if `i_wb_ready` stays low, the block stays in RESP indefinitely and `o_ready` stays 0.
- No stage is bypassed. All outputs are registered except `o_ready`, which is a state decode.

## Configuration
- Macro: `MDU_ISSUE_FASTDIV_EN`.
- Defined: for funct3 4–7, the block resolves the following in IDLE and goes straight to RESP with 1-cycle latency, never asserting `o_mdu_valid`:
  - rs2 = 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- Undefined: every operation goes through BUSY, and the result is whatever `mdu_top` returns.

## Test plan
- MUL 7 × −3 (rs1=7, rs2=0xFFFFFFFD, rd=5), `i_mdu_ready` modelled at cycle 3 → `o_mdu_valid` high in cycles 1–3; `o_wb_valid` in cycle 4 with `o_wb_rd`=5 and `o_wb_data`=0xFFFFFFEB; `o_ready`=1 again in cycle 5.
- DIVU 100/7 with the real `mdu_top` → `o_wb_data`=14. Operands and op stay constant throughout BUSY, and `o_mdu_valid` is low for at least one cycle before the next REMU 100/7 is issued, which returns 2.
- `i_wb_ready` held low for 10 cycles in RESP → `o_wb_data` is stable, `o_ready`=0, and `i_valid` is ignored; result retires on the first cycle `i_wb_ready`=1.
- Reset asserted in BUSY during DIV → outputs go to 0 asynchronously and no `o_wb_valid` appears. A following MULHU 0xFFFFFFFF×0xFFFFFFFF returns 0xFFFFFFFE.
- With `MDU_ISSUE_FASTDIV_EN`:
  - DIV 5/0 → 0xFFFFFFFF in cycle 1 with `o_mdu_valid` never high.
  - REM 0x80000000/−1 → 0.
  - Without the macro, both cases pass through the unit.
- `i_mdu_ready` pulsed while in IDLE, and `i_wb_ready` pulsed while in BUSY → no state change.
